// File: rtl/io_capture_pkg.sv
// Shared definitions for the io_out UART capture block: TX state encoding and frame geometry.
package io_capture_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // start + 8 data + stop
  localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter with valid/ready load handshake; tx is registered from the current state.
module uart_tx_8n1
  import io_capture_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       active,
  output logic       tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST = 3'(UART_FRAME_BITS - 3);

  tx_state_e         state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt, baud_nxt;
  logic [2:0]        bit_cnt, bit_nxt;
  logic [7:0]        shift, shift_nxt;
  logic              tx_nxt;
  logic              baud_wrap;
  logic              load;

  assign ready     = (state == TX_IDLE);
  assign active    = (state != TX_IDLE);
  assign load      = valid && ready;
  assign baud_wrap = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      tx       <= tx_nxt;
    end
  end

  // Data register carries no reset; it is always loaded before it is shifted out.
  always_ff @(posedge clk) begin
    shift <= shift_nxt;
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    tx_nxt    = 1'b1;
    case (state)
      TX_IDLE: begin
        if (load) begin
          state_nxt = TX_START;
          shift_nxt = data;
          bit_nxt   = '0;
          baud_nxt  = '0;
        end
      end
      TX_START: begin
        tx_nxt = 1'b0;
        if (baud_wrap) begin
          baud_nxt  = '0;
          state_nxt = TX_DATA;
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      TX_DATA: begin
        tx_nxt = shift[0];
        if (baud_wrap) begin
          baud_nxt  = '0;
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_cnt == BIT_LAST) begin
            state_nxt = TX_STOP;
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      TX_STOP: begin
        tx_nxt = 1'b1;
        if (baud_wrap) begin
          baud_nxt  = '0;
          state_nxt = TX_IDLE;
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        state_nxt = TX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/io_out_uart_capture.sv
// Captures a user module's io_out bus into a small FIFO and streams queued bytes out as 8N1 UART frames.
module io_out_uart_capture
  import io_capture_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int CHANGE_ONLY  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  sample_in,
  input  logic                        sample_en,
  output logic                        tx,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic [7:0]       last_val;
  logic             first_flag;

  logic             want_push;
  logic             push;
  logic             pop;
  logic             full;
  logic             tx_ready;
  logic             tx_active;

  assign want_push = sample_en &&
                     ((CHANGE_ONLY == 0) || first_flag || (sample_in != last_val));
  assign full      = (level == LVL_FULL);
  assign pop       = tx_ready && (level != '0);
  // A full FIFO still takes the byte when the transmitter drains a slot this same cycle.
  assign push      = want_push && (!full || pop);

  assign busy       = tx_active || (level != '0);
  assign fifo_level = level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_val   <= 8'h00;
      first_flag <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (want_push) begin
        last_val   <= sample_in;
        first_flag <= 1'b0;
        if (!push) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (pop && !push) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .valid (level != '0),
    .data  (mem[rd_ptr]),
    .ready (tx_ready),
    .active(tx_active),
    .tx    (tx)
  );

endmodule

// File: tb/tb_io_out_uart_capture.sv
// Self-checking bench for io_out_uart_capture: UART line decoder feeding a byte scoreboard plus timing checks.
module tb_io_out_uart_capture;

  localparam int C   = 4;
  localparam int MID = C / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sample_in = 8'h00;
  logic       sample_en = 1'b0;
  logic       tx, busy, overflow;
  logic [2:0] fifo_level;

  logic [7:0] sample_in2 = 8'h00;
  logic       sample_en2 = 1'b0;
  logic       tx2, busy2, overflow2;
  logic [2:0] fifo_level2;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  bit         mon_active = 1'b0;
  int         mon_idx = 0;
  logic [7:0] mon_byte = 8'h00;
  int         frame_err = 0;

  always #5 clk = ~clk;

  io_out_uart_capture #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4), .CHANGE_ONLY(1)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_en(sample_en),
    .tx(tx), .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
  );

  io_out_uart_capture #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4), .CHANGE_ONLY(0)) dut2 (
    .clk(clk), .reset(reset), .sample_in(sample_in2), .sample_en(sample_en2),
    .tx(tx2), .busy(busy2), .overflow(overflow2), .fifo_level(fifo_level2)
  );

  // UART line decoder: samples mid-bit on negedges, abandons a frame when reset is seen.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (tx == 1'b0) begin
          mon_active = 1'b1;
          mon_idx = 0;
        end
      end else begin
        mon_idx++;
        for (int i = 0; i < 8; i++) begin
          if (mon_idx == MID + C * (i + 1)) mon_byte[i] = tx;
        end
        if (mon_idx == MID + 9 * C) begin
          if (tx === 1'b1) rx_q.push_back(mon_byte);
          else frame_err++;
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    sample_en = 1'b0;
    sample_en2 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    sample_en = 1'b0;
    #1;
    total++;
    if ({tx, busy, overflow, fifo_level} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL reset_state: tx/busy/ovf/level=%b/%b/%b/%0d required 1/0/0/0",
               tx, busy, overflow, fifo_level);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      total++;
      if ({tx, busy, fifo_level} !== {1'b1, 1'b0, 3'd0}) begin
        bad++;
        $display("FAIL idle_cycle%0d: tx/busy/level=%b/%b/%0d required 1/0/0", k, tx, busy, fifo_level);
      end
    end
  endtask

  task automatic test_single_a5();
    logic [7:0] b;
    logic       exp_tx, exp_busy, r, e;
    bit ok;
    b = 8'hA5;
    apply_reset();
    sample_in = b;
    sample_en = 1'b1;
    exp_q.push_back(b);
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    total++;
    if ({tx, busy, fifo_level} !== {1'b1, 1'b1, 3'd1}) begin
      bad++;
      $display("FAIL a5_capture: tx/busy/level=%b/%b/%0d required 1/1/1", tx, busy, fifo_level);
    end
    for (int k = 1; k <= 41; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) exp_tx = 1'b1;
      else if (k <= 5) exp_tx = 1'b0;
      else if (k <= 37) exp_tx = b[(k - 6) / 4];
      else exp_tx = 1'b1;
      exp_busy = (k <= 40);
      total++;
      if (tx !== exp_tx || busy !== exp_busy) begin
        bad++;
        $display("FAIL a5_timing_edge%0d: tx=%b busy=%b required tx=%b busy=%b", k, tx, busy, exp_tx, exp_busy);
      end
    end
    wait_rx(1, 50, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL a5_timeout: frames=%0d required 1", rx_q.size());
    end
    while (exp_q.size() > 0) begin
      e = 1'b0;
      r = 1'b0;
      begin
        logic [7:0] ev, rv;
        ev = exp_q.pop_front();
        total++;
        if (rx_q.size() == 0) begin
          bad++;
          $display("FAIL a5_frame: got none required %h", ev);
        end else begin
          rv = rx_q.pop_front();
          if (rv !== ev) begin
            bad++;
            $display("FAIL a5_frame: got %h required %h", rv, ev);
          end
        end
      end
    end
  endtask

  task automatic test_change_only();
    logic [7:0] seq[4];
    logic [7:0] ev, rv;
    bit ok;
    seq = '{8'h00, 8'h00, 8'h3C, 8'h3C};
    apply_reset();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h3C);
    for (int i = 0; i < 4; i++) begin
      sample_in = seq[i];
      sample_en = 1'b1;
      @(negedge clk);
    end
    sample_en = 1'b0;
    wait_rx(2, 300, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL change_timeout: frames=%0d required 2", rx_q.size());
    end
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      total++;
      if (rx_q.size() == 0) begin
        bad++;
        $display("FAIL change_frame: got none required %h", ev);
      end else begin
        rv = rx_q.pop_front();
        if (rv !== ev) begin
          bad++;
          $display("FAIL change_frame: got %h required %h", rv, ev);
        end
      end
    end
    repeat (100) @(negedge clk);
    total++;
    if (rx_q.size() != 0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL change_extra: extra_frames=%0d ovf=%b required 0/0", rx_q.size(), overflow);
    end
  endtask

  task automatic test_burst_overflow();
    logic [7:0] ev, rv;
    bit ok;
    apply_reset();
    for (int i = 1; i <= 6; i++) begin
      sample_in = 8'(i);
      sample_en = 1'b1;
      if (i <= 5) exp_q.push_back(8'(i));
      @(negedge clk);
    end
    sample_en = 1'b0;
    total++;
    if (overflow !== 1'b1 || fifo_level !== 3'd4) begin
      bad++;
      $display("FAIL burst_full: ovf=%b level=%0d required 1/4", overflow, fifo_level);
    end
    wait_rx(5, 600, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL burst_timeout: frames=%0d required 5", rx_q.size());
    end
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      total++;
      if (rx_q.size() == 0) begin
        bad++;
        $display("FAIL burst_frame: got none required %h", ev);
      end else begin
        rv = rx_q.pop_front();
        if (rv !== ev) begin
          bad++;
          $display("FAIL burst_frame: got %h required %h", rv, ev);
        end
      end
    end
    repeat (60) @(negedge clk);
    total++;
    if (overflow !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0 || rx_q.size() != 0) begin
      bad++;
      $display("FAIL burst_after: ovf=%b busy=%b level=%0d extra=%0d required 1/0/0/0",
               overflow, busy, fifo_level, rx_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] ev, rv;
    int lows;
    bit ok;
    apply_reset();
    sample_in = 8'hFF; sample_en = 1'b1; @(negedge clk);
    sample_in = 8'h11; @(negedge clk);
    sample_in = 8'h22; @(negedge clk);
    sample_en = 1'b0;
    total++;
    if (fifo_level !== 3'd2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_queued: level=%0d busy=%b required 2/1", fifo_level, busy);
    end
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({tx, fifo_level, overflow, busy} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midrst_state: tx/level/ovf/busy=%b/%0d/%b/%b required 1/0/0/0",
               tx, fifo_level, overflow, busy);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lows = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    total++;
    if (lows != 0 || rx_q.size() != 0) begin
      bad++;
      $display("FAIL midrst_quiet: low_cycles=%0d frames=%0d required 0/0", lows, rx_q.size());
    end
    sample_in = 8'h77;
    sample_en = 1'b1;
    exp_q.push_back(8'h77);
    @(negedge clk);
    sample_en = 1'b0;
    wait_rx(1, 100, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL midrst_timeout: frames=%0d required 1", rx_q.size());
    end
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      total++;
      if (rx_q.size() == 0) begin
        bad++;
        $display("FAIL midrst_frame: got none required %h", ev);
      end else begin
        rv = rx_q.pop_front();
        if (rv !== ev) begin
          bad++;
          $display("FAIL midrst_frame: got %h required %h", rv, ev);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       rec[300];
    logic [7:0] ev, rv;
    int s0, s;
    apply_reset();
    sample_in2 = 8'h55;
    sample_en2 = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      rec[k] = tx2;
    end
    sample_en2 = 1'b0;
    s0 = -1;
    for (int k = 0; k < 300; k++) begin
      if (s0 < 0 && rec[k] === 1'b0) s0 = k;
    end
    total++;
    if (s0 < 1 || s0 > 20) begin
      bad++;
      $display("FAIL b2b_start: first start index=%0d required 1..20", s0);
    end else begin
      for (int f = 0; f < 5; f++) begin
        s = s0 + 41 * f;
        exp_q.push_back(8'h55);
        for (int i = 0; i < 8; i++) rv[i] = rec[s + MID + C * (i + 1)];
        rx_q.push_back(rv);
        ev = exp_q.pop_front();
        rv = rx_q.pop_front();
        total++;
        if (rv !== ev || rec[s + MID + 9 * C] !== 1'b1) begin
          bad++;
          $display("FAIL b2b_frame%0d: got %h stop=%b required %h stop=1", f, rv, rec[s + MID + 9 * C], ev);
        end
        if (f < 4) begin
          total++;
          if (rec[s + 40] !== 1'b1 || rec[s + 41] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap%0d: tx at +40/+41=%b/%b required 1/0", f, rec[s + 40], rec[s + 41]);
          end
        end
      end
    end
    total++;
    if (overflow2 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_overflow: ovf=%b required 1", overflow2);
    end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_change_only();
    test_burst_overflow();
    test_reset_mid_frame();
    test_back_to_back();
    total++;
    if (frame_err != 0) begin
      bad++;
      $display("FAIL framing: stop_errors=%0d required 0", frame_err);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
